// File: rtl/udma_spim_pkg.sv
// Shared types and helpers for the SPI master command arbiter.
`include "udma_spim_defines.sv"

package udma_spim_pkg;

    localparam int CMD_W = 32;

    typedef enum logic {
        S_ARB_IDLE,
        S_ARB_LOCKED
    } arb_state_e;

    // Only the opcode field is inspected; the payload passes through untouched.
    function automatic logic isEot(input logic [CMD_W-1:0] cmd);
        return cmd[31:28] == `SPI_CMD_EOT;
    endfunction

endpackage

// File: rtl/udma_spim_cmd_arb_if.sv
// Command-stream bundle: N_SRC requesting streams in, one SPI command stream out.
interface udma_spim_cmd_arb_if
    import udma_spim_pkg::*;
#(
    parameter int N_SRC = 2
);

    logic [N_SRC-1:0][CMD_W-1:0] srcCmd;
    logic [N_SRC-1:0]            srcValid;
    logic [N_SRC-1:0]            srcReady;
    logic [CMD_W-1:0]            cmd;
    logic                        cmdValid;
    logic                        cmdReady;

    modport master (
        output srcCmd, srcValid,
        input  srcReady,
        input  cmd, cmdValid,
        output cmdReady
    );

    modport slave (
        input  srcCmd, srcValid,
        output srcReady,
        output cmd, cmdValid,
        input  cmdReady
    );

endinterface

// File: rtl/udma_spim_cmd_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module udma_spim_rr_pick
    import udma_spim_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_SRC-1:0] gnt_o,
    output logic             valid_o
);

    localparam logic [PTR_W:0] NSRC_V = (PTR_W+1)'(N_SRC);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (sum >= NSRC_V) begin
                sum = sum - NSRC_V;
            end
            idx = sum[PTR_W-1:0];
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udma_spim_defines.sv
// SPI master command opcodes, carried in bits [31:28] of every command word.
`ifndef UDMA_SPIM_DEFINES_SV
`define UDMA_SPIM_DEFINES_SV

`define SPI_CMD_CFG       4'b0000
`define SPI_CMD_SOT       4'b0001
`define SPI_CMD_SEND_CMD  4'b0010
`define SPI_CMD_SEND_ADDR 4'b0011
`define SPI_CMD_DUMMY     4'b0100
`define SPI_CMD_WAIT      4'b0101
`define SPI_CMD_TX_DATA   4'b0110
`define SPI_CMD_RX_DATA   4'b0111
`define SPI_CMD_RPT       4'b1000
`define SPI_CMD_EOT       4'b1001
`define SPI_CMD_RPT_END   4'b1010
`define SPI_CMD_RX_CHECK  4'b1011
`define SPI_CMD_FULL_DUPL 4'b1100
`define SPI_CMD_SETUP_UCA 4'b1101
`define SPI_CMD_SETUP_UCS 4'b1110

`endif

// File: rtl/udma_spim_cmd_arb.sv
// Shares the SPI master command channel between N_SRC streams with atomic,
// round-robin transactions terminated by an EOT word or an idle timeout.
module udma_spim_cmd_arb
    import udma_spim_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    udma_spim_cmd_arb_if.slave   arb_if,
    input  logic                 cfg_en_i,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    output logic [N_SRC-1:0]     grant_o,
    output logic                 busy_o,
    output logic                 timeout_evt_o
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    arb_state_e           state_q;
    logic [N_SRC-1:0]     grant_q;
    logic [PTR_W-1:0]     gidx_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [CMD_W-1:0]     cmd_q;
    logic                 cmdValid_q;
    logic [TIMEOUT_W-1:0] tmoCnt_q;
    logic                 tmoEvt_q;

    logic [N_SRC-1:0] pickGnt;
    logic             pickValid;
    logic [PTR_W-1:0] pickIdx;
    logic [PTR_W-1:0] nextPtr_d;
    logic [CMD_W-1:0] srcWord;
    logic             srcValidG;
    logic             locked;
    logic             outFree;
    logic             accept;
    logic             eotAccept;
    logic             tmoHit;

    udma_spim_rr_pick #(
        .N_SRC (N_SRC),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i   (arb_if.srcValid),
        .ptr_i   (ptr_q),
        .gnt_o   (pickGnt),
        .valid_o (pickValid)
    );

    always_comb begin
        pickIdx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pickGnt[i]) begin
                pickIdx = PTR_W'(i);
            end
        end
    end

    assign locked    = (state_q == S_ARB_LOCKED);
    assign srcWord   = arb_if.srcCmd[gidx_q];
    assign srcValidG = arb_if.srcValid[gidx_q];
    // The output register can take a new word whenever it is empty or draining this cycle.
    assign outFree   = ~cmdValid_q | arb_if.cmdReady;
    assign accept    = locked & srcValidG & outFree;
    assign eotAccept = accept & isEot(srcWord);
    assign tmoHit    = locked & (cfg_timeout_i != '0) & (tmoCnt_q >= cfg_timeout_i);
    assign nextPtr_d = (gidx_q == PTR_W'(N_SRC - 1)) ? '0 : gidx_q + 1'b1;

    assign arb_if.srcReady = (locked & outFree) ? grant_q : '0;
    assign arb_if.cmd      = cmd_q;
    assign arb_if.cmdValid = cmdValid_q;
    assign grant_o         = grant_q;
    assign busy_o          = locked | cmdValid_q;
    assign timeout_evt_o   = tmoEvt_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= S_ARB_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
            cmd_q      <= '0;
            cmdValid_q <= 1'b0;
            tmoCnt_q   <= '0;
            tmoEvt_q   <= 1'b0;
        end else begin
            tmoEvt_q <= 1'b0;

            if (accept) begin
                cmd_q      <= srcWord;
                cmdValid_q <= 1'b1;
            end else if (arb_if.cmdReady) begin
                cmdValid_q <= 1'b0;
            end

            case (state_q)
                S_ARB_IDLE: begin
                    if (cfg_en_i && pickValid) begin
                        state_q  <= S_ARB_LOCKED;
                        grant_q  <= pickGnt;
                        gidx_q   <= pickIdx;
                        tmoCnt_q <= '0;
                    end
                end
                S_ARB_LOCKED: begin
                    // An EOT accepted on the timeout cycle ends the transaction cleanly.
                    if (eotAccept) begin
                        state_q  <= S_ARB_IDLE;
                        grant_q  <= '0;
                        ptr_q    <= nextPtr_d;
                        tmoCnt_q <= '0;
                    end else if (tmoHit) begin
                        state_q  <= S_ARB_IDLE;
                        grant_q  <= '0;
                        ptr_q    <= nextPtr_d;
                        tmoCnt_q <= '0;
                        tmoEvt_q <= 1'b1;
                    end else if (accept) begin
                        tmoCnt_q <= '0;
                    end else if (!srcValidG && (tmoCnt_q != '1)) begin
                        tmoCnt_q <= tmoCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    grantOneHot: assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(grant_q));

endmodule
